// File: rtl/lieat_exu_fpu_arb.sv
// Round-robin arbiter sharing one FPU between the scalar (0) and vector (1) issue pipes.
// An in-order ordering FIFO tracks owner/pc/rd per issued op and steers results back.
module lieat_exu_fpu_arb #(
    parameter int XLEN    = 32,
    parameter int REG_IDX = 5,
    parameter int DEPTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush_req,

    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*XLEN-1:0]    req_pc,
    input  logic [2*REG_IDX-1:0] req_rd,
    input  logic [1:0]           req_rdwen,
    input  logic [2*XLEN-1:0]    req_imm,
    input  logic [2*XLEN-1:0]    req_src1,
    input  logic [2*XLEN-1:0]    req_src2,
    input  logic [63:0]          req_infobus,

    output logic                 fpu_i_valid,
    input  logic                 fpu_i_ready,
    output logic [XLEN-1:0]      fpu_i_pc,
    output logic [REG_IDX-1:0]   fpu_i_rd,
    output logic                 fpu_i_rdwen,
    output logic [XLEN-1:0]      fpu_i_imm,
    output logic [XLEN-1:0]      fpu_i_src1,
    output logic [XLEN-1:0]      fpu_i_src2,
    output logic [31:0]          fpu_i_infobus,

    input  logic                 fpu_o_valid,
    output logic                 fpu_o_ready,
    input  logic [XLEN-1:0]      fpu_o_data,
    output logic                 fpu_flush,

    output logic [1:0]           resp_valid,
    input  logic [1:0]           resp_ready,
    output logic [XLEN-1:0]      resp_pc,
    output logic [REG_IDX-1:0]   resp_rd,
    output logic                 resp_wen,
    output logic [XLEN-1:0]      resp_data,

    output logic                 busy,
    output logic                 err_orphan
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0]   q_owner;
    logic [DEPTH-1:0]   q_wen;
    logic [XLEN-1:0]    q_pc [DEPTH];
    logic [REG_IDX-1:0] q_rd [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          rr_ptr;

    logic can_issue;
    logic grant;
    logic empty;
    logic head_owner;
    logic push;
    logic pop;
    logic orphan_hit;

    // Arbitration: grant = 1 selects the vector pipe.
    always_comb begin
        can_issue   = (count < (AW+1)'(DEPTH)) & ~flush_req;
        grant       = ~(req_valid[0] & (~rr_ptr | ~req_valid[1]));
        fpu_i_valid = can_issue & (|req_valid);
        req_ready   = '0;
        if (can_issue && fpu_i_ready) begin
            if (grant) req_ready[1] = req_valid[1];
            else       req_ready[0] = req_valid[0];
        end
        fpu_i_pc      = grant ? req_pc[2*XLEN-1:XLEN]        : req_pc[XLEN-1:0];
        fpu_i_rd      = grant ? req_rd[2*REG_IDX-1:REG_IDX]  : req_rd[REG_IDX-1:0];
        fpu_i_rdwen   = grant ? req_rdwen[1]                 : req_rdwen[0];
        fpu_i_imm     = grant ? req_imm[2*XLEN-1:XLEN]       : req_imm[XLEN-1:0];
        fpu_i_src1    = grant ? req_src1[2*XLEN-1:XLEN]      : req_src1[XLEN-1:0];
        fpu_i_src2    = grant ? req_src2[2*XLEN-1:XLEN]      : req_src2[XLEN-1:0];
        fpu_i_infobus = grant ? req_infobus[63:32]           : req_infobus[31:0];
    end

    // Return path: head entry steers the result; an empty FIFO drains orphans.
    always_comb begin
        empty       = (count == '0);
        head_owner  = q_owner[rd_ptr];
        resp_valid  = '0;
        if (fpu_o_valid && !empty && !flush_req) resp_valid[head_owner] = 1'b1;
        fpu_o_ready = ~flush_req & (empty ? fpu_o_valid : resp_ready[head_owner]);
        resp_pc     = q_pc[rd_ptr];
        resp_rd     = q_rd[rd_ptr];
        resp_wen    = q_wen[rd_ptr];
        resp_data   = fpu_o_data;
        push        = fpu_i_valid & fpu_i_ready;
        pop         = fpu_o_valid & fpu_o_ready & ~empty;
        orphan_hit  = fpu_o_valid & empty & ~flush_req;
        fpu_flush   = flush_req;
        busy        = ~empty;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rr_ptr     <= 1'b0;
            err_orphan <= 1'b0;
        end else if (flush_req) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= ~grant;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (orphan_hit) err_orphan <= 1'b1;
        end
    end

    // Entry storage needs no reset: it is only read behind a valid count.
    always_ff @(posedge clock) begin
        if (push) begin
            q_owner[wr_ptr] <= grant;
            q_wen[wr_ptr]   <= fpu_i_rdwen;
            q_pc[wr_ptr]    <= fpu_i_pc;
            q_rd[wr_ptr]    <= fpu_i_rd;
        end
    end

endmodule

// File: tb/tb_lieat_exu_fpu_arb.sv
// Scenario bench for lieat_exu_fpu_arb: directed tasks plus a randomized run
// against a queue-based model of issue ordering and result routing.
module tb_lieat_exu_fpu_arb;

    localparam int XLEN    = 32;
    localparam int REG_IDX = 5;
    localparam int DEPTH   = 4;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 flush_req;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [2*XLEN-1:0]    req_pc;
    logic [2*REG_IDX-1:0] req_rd;
    logic [1:0]           req_rdwen;
    logic [2*XLEN-1:0]    req_imm;
    logic [2*XLEN-1:0]    req_src1;
    logic [2*XLEN-1:0]    req_src2;
    logic [63:0]          req_infobus;
    logic                 fpu_i_valid;
    logic                 fpu_i_ready;
    logic [XLEN-1:0]      fpu_i_pc;
    logic [REG_IDX-1:0]   fpu_i_rd;
    logic                 fpu_i_rdwen;
    logic [XLEN-1:0]      fpu_i_imm;
    logic [XLEN-1:0]      fpu_i_src1;
    logic [XLEN-1:0]      fpu_i_src2;
    logic [31:0]          fpu_i_infobus;
    logic                 fpu_o_valid;
    logic                 fpu_o_ready;
    logic [XLEN-1:0]      fpu_o_data;
    logic                 fpu_flush;
    logic [1:0]           resp_valid;
    logic [1:0]           resp_ready;
    logic [XLEN-1:0]      resp_pc;
    logic [REG_IDX-1:0]   resp_rd;
    logic                 resp_wen;
    logic [XLEN-1:0]      resp_data;
    logic                 busy;
    logic                 err_orphan;

    int n_cmp = 0;
    int n_bad = 0;

    lieat_exu_fpu_arb #(.XLEN(XLEN), .REG_IDX(REG_IDX), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .flush_req(flush_req),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc), .req_rd(req_rd),
        .req_rdwen(req_rdwen), .req_imm(req_imm), .req_src1(req_src1), .req_src2(req_src2),
        .req_infobus(req_infobus),
        .fpu_i_valid(fpu_i_valid), .fpu_i_ready(fpu_i_ready), .fpu_i_pc(fpu_i_pc),
        .fpu_i_rd(fpu_i_rd), .fpu_i_rdwen(fpu_i_rdwen), .fpu_i_imm(fpu_i_imm),
        .fpu_i_src1(fpu_i_src1), .fpu_i_src2(fpu_i_src2), .fpu_i_infobus(fpu_i_infobus),
        .fpu_o_valid(fpu_o_valid), .fpu_o_ready(fpu_o_ready), .fpu_o_data(fpu_o_data),
        .fpu_flush(fpu_flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pc(resp_pc),
        .resp_rd(resp_rd), .resp_wen(resp_wen), .resp_data(resp_data),
        .busy(busy), .err_orphan(err_orphan)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic                owner;
        logic [XLEN-1:0]     pc;
        logic [REG_IDX-1:0]  rd;
        logic                wen;
    } op_t;

    task automatic idle_inputs();
        flush_req   = 1'b0;
        req_valid   = '0;
        req_pc      = '0;
        req_rd      = '0;
        req_rdwen   = '0;
        req_imm     = '0;
        req_src1    = '0;
        req_src2    = '0;
        req_infobus = '0;
        fpu_i_ready = 1'b0;
        fpu_o_valid = 1'b0;
        fpu_o_data  = '0;
        resp_ready  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        #1;
        n_cmp++;
        if ({req_ready, fpu_i_valid, resp_valid, busy, err_orphan, fpu_flush} !== 8'b0) begin
            n_bad++;
            $display("FAIL reset: rr=%b iv=%b rv=%b busy=%b orph=%b fl=%b, want all 0",
                     req_ready, fpu_i_valid, resp_valid, busy, err_orphan, fpu_flush);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_req();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            req_valid = 2'b01; fpu_i_ready = 1'b1;
            req_pc[XLEN-1:0] = 32'h100 + 32'(i);
            #1;
            n_cmp++;
            if (req_ready !== 2'b01 || fpu_i_pc !== 32'h100 + 32'(i)) begin
                n_bad++;
                $display("FAIL single_issue%0d: ready=%b pc=%h, want 01 %h", i, req_ready, fpu_i_pc, 32'h100 + 32'(i));
            end
        end
        @(negedge clock);
        req_valid = '0; fpu_i_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            fpu_o_valid = 1'b1; fpu_o_data = 32'hA0 + 32'(j); resp_ready = 2'b11;
            #1;
            n_cmp++;
            if (resp_valid !== 2'b01 || resp_pc !== 32'h100 + 32'(j) || resp_data !== 32'hA0 + 32'(j)
                || fpu_o_ready !== 1'b1 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL single_resp%0d: rv=%b pc=%h data=%h ordy=%b busy=%b, want 01 %h %h 1 1",
                         j, resp_valid, resp_pc, resp_data, fpu_o_ready, busy, 32'h100 + 32'(j), 32'hA0 + 32'(j));
            end
            @(negedge clock);
            fpu_o_valid = 1'b0;
        end
        #1;
        n_cmp++;
        if (busy !== 1'b0 || err_orphan !== 1'b0) begin
            n_bad++;
            $display("FAIL single_drain: busy=%b orph=%b, want 0 0", busy, err_orphan);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            req_valid = 2'b11; fpu_i_ready = 1'b1;
            req_pc = {32'h2000 + 32'(i*4), 32'h1000 + 32'(i*4)};
            #1;
            n_cmp++;
            if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10) ||
                fpu_i_pc !== ((i % 2 == 0) ? 32'h1000 : 32'h2000) + 32'(i*4)) begin
                n_bad++;
                $display("FAIL alt_grant%0d: ready=%b pc=%h", i, req_ready, fpu_i_pc);
            end
        end
        @(negedge clock);
        req_valid = '0; fpu_i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fpu_o_valid = 1'b1; resp_ready = 2'b11;
            #1;
            n_cmp++;
            if (resp_valid !== ((k % 2 == 0) ? 2'b01 : 2'b10) ||
                resp_pc !== ((k % 2 == 0) ? 32'h1000 : 32'h2000) + 32'(k*4)) begin
                n_bad++;
                $display("FAIL alt_resp%0d: rv=%b pc=%h", k, resp_valid, resp_pc);
            end
            @(negedge clock);
        end
        fpu_o_valid = 1'b0;
    endtask

    task automatic test_full();
        int accepted = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            req_valid = 2'b01; fpu_i_ready = 1'b1;
            #1;
            if (req_ready[0]) accepted++;
        end
        n_cmp++;
        if (accepted != DEPTH || req_ready !== 2'b00 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL full_accept: accepted=%0d ready=%b busy=%b, want %0d 00 1", accepted, req_ready, busy, DEPTH);
        end
        @(negedge clock);
        fpu_o_valid = 1'b1; resp_ready = 2'b11;
        #1;
        n_cmp++;
        if (fpu_o_ready !== 1'b1 || req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL full_pop_cycle: ordy=%b ready=%b, want 1 00", fpu_o_ready, req_ready);
        end
        @(negedge clock);
        fpu_o_valid = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL full_after_pop: ready=%b, want 01", req_ready);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clock);
        req_valid = 2'b10; fpu_i_ready = 1'b1; req_pc = {32'h3000, 32'h0};
        @(negedge clock);
        req_valid = '0; fpu_i_ready = 1'b0;
        fpu_o_valid = 1'b1; fpu_o_data = 32'h55; resp_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (fpu_o_ready !== 1'b0 || resp_valid !== 2'b10 || busy !== 1'b1 || resp_pc !== 32'h3000) begin
                n_bad++;
                $display("FAIL bp_hold%0d: ordy=%b rv=%b busy=%b pc=%h, want 0 10 1 3000",
                         i, fpu_o_ready, resp_valid, busy, resp_pc);
            end
            @(negedge clock);
        end
        resp_ready = 2'b11;
        #1;
        n_cmp++;
        if (fpu_o_ready !== 1'b1 || resp_valid !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_release: ordy=%b rv=%b, want 1 10", fpu_o_ready, resp_valid);
        end
        @(negedge clock);
        fpu_o_valid = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || err_orphan !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_single_pop: busy=%b orph=%b, want 0 0", busy, err_orphan);
        end
    endtask

    task automatic test_flush();
        do_reset();
        req_pc = {32'h4100, 32'h4000};
        @(negedge clock);
        req_valid = 2'b10; fpu_i_ready = 1'b1;
        @(negedge clock);
        req_valid = 2'b01;
        @(negedge clock);
        req_valid = 2'b11; flush_req = 1'b1; fpu_o_valid = 1'b1; resp_ready = 2'b11;
        #1;
        n_cmp++;
        if (fpu_flush !== 1'b1 || resp_valid !== 2'b00 || fpu_i_valid !== 1'b0 ||
            req_ready !== 2'b00 || fpu_o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_cycle: fl=%b rv=%b iv=%b rr=%b ordy=%b, want 1 00 0 00 0",
                     fpu_flush, resp_valid, fpu_i_valid, req_ready, fpu_o_ready);
        end
        @(negedge clock);
        flush_req = 1'b0; fpu_o_valid = 1'b0; fpu_i_ready = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || err_orphan !== 1'b0 || fpu_flush !== 1'b0 || fpu_i_pc !== 32'h4100) begin
            n_bad++;
            $display("FAIL flush_after: busy=%b orph=%b fl=%b pc=%h, want 0 0 0 4100",
                     busy, err_orphan, fpu_flush, fpu_i_pc);
        end
    endtask

    task automatic test_orphan();
        do_reset();
        @(negedge clock);
        fpu_o_valid = 1'b1;
        #1;
        n_cmp++;
        if (fpu_o_ready !== 1'b1 || resp_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL orphan_drain: ordy=%b rv=%b, want 1 00", fpu_o_ready, resp_valid);
        end
        @(negedge clock);
        fpu_o_valid = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_cmp++;
        if (err_orphan !== 1'b1) begin
            n_bad++;
            $display("FAIL orphan_sticky: orph=%b, want 1", err_orphan);
        end
        do_reset();
        #1;
        n_cmp++;
        if (err_orphan !== 1'b0) begin
            n_bad++;
            $display("FAIL orphan_reset: orph=%b, want 0", err_orphan);
        end
    endtask

    // Model: a queue of issued ops in order, plus which lane gets preference on a tie.
    task automatic test_random();
        op_t q[$];
        op_t head;
        int  pref;
        int  win;
        logic       exp_iv;
        logic [1:0] exp_rr;
        logic [1:0] exp_rv;
        logic       exp_or;
        do_reset();
        pref = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            req_valid   = 2'($urandom);
            req_pc      = {$urandom, $urandom};
            req_rd      = 10'($urandom);
            req_rdwen   = 2'($urandom);
            req_imm     = {$urandom, $urandom};
            req_src1    = {$urandom, $urandom};
            req_src2    = {$urandom, $urandom};
            req_infobus = {$urandom, $urandom};
            fpu_i_ready = ($urandom_range(0, 3) != 0);
            fpu_o_valid = (q.size() != 0) && ($urandom_range(0, 2) != 0);
            fpu_o_data  = $urandom;
            resp_ready  = 2'($urandom);
            flush_req   = ($urandom_range(0, 19) == 0);
            #1;
            win    = (req_valid == 2'b11) ? pref : (req_valid[0] ? 0 : 1);
            exp_iv = !flush_req && (q.size() < DEPTH) && (req_valid != 0);
            exp_rr = (exp_iv && fpu_i_ready) ? 2'(1 << win) : 2'b00;
            n_cmp++;
            if (fpu_i_valid !== exp_iv || req_ready !== exp_rr) begin
                n_bad++;
                $display("FAIL rand_issue c%0d: iv=%b rr=%b, want %b %b", cyc, fpu_i_valid, req_ready, exp_iv, exp_rr);
            end
            if (exp_iv) begin
                n_cmp++;
                if (fpu_i_pc !== req_pc[win*XLEN +: XLEN] || fpu_i_rd !== req_rd[win*REG_IDX +: REG_IDX] ||
                    fpu_i_rdwen !== req_rdwen[win] || fpu_i_imm !== req_imm[win*XLEN +: XLEN] ||
                    fpu_i_src1 !== req_src1[win*XLEN +: XLEN] || fpu_i_src2 !== req_src2[win*XLEN +: XLEN] ||
                    fpu_i_infobus !== req_infobus[win*32 +: 32]) begin
                    n_bad++;
                    $display("FAIL rand_payload c%0d: pc=%h, want lane %0d pc %h", cyc, fpu_i_pc, win, req_pc[win*XLEN +: XLEN]);
                end
            end
            head   = (q.size() != 0) ? q[0] : '0;
            exp_rv = (fpu_o_valid && q.size() != 0 && !flush_req) ? 2'(1 << head.owner) : 2'b00;
            exp_or = !flush_req && ((q.size() == 0) ? fpu_o_valid : resp_ready[head.owner]);
            n_cmp++;
            if (resp_valid !== exp_rv || busy !== (q.size() != 0) || err_orphan !== 1'b0 ||
                fpu_flush !== flush_req || (q.size() != 0 && fpu_o_ready !== exp_or)) begin
                n_bad++;
                $display("FAIL rand_return c%0d: rv=%b busy=%b orph=%b fl=%b ordy=%b, want %b %b 0 %b %b",
                         cyc, resp_valid, busy, err_orphan, fpu_flush, fpu_o_ready,
                         exp_rv, (q.size() != 0), flush_req, exp_or);
            end
            if (exp_rv != 0) begin
                n_cmp++;
                if (resp_pc !== head.pc || resp_rd !== head.rd || resp_wen !== head.wen || resp_data !== fpu_o_data) begin
                    n_bad++;
                    $display("FAIL rand_resp c%0d: pc=%h rd=%0d wen=%b data=%h, want %h %0d %b %h",
                             cyc, resp_pc, resp_rd, resp_wen, resp_data, head.pc, head.rd, head.wen, fpu_o_data);
                end
            end
            if (flush_req) begin
                q.delete();
            end else begin
                if (exp_rv != 0 && resp_ready[head.owner]) void'(q.pop_front());
                if (exp_iv && fpu_i_ready) begin
                    q.push_back('{owner: 1'(win), pc: req_pc[win*XLEN +: XLEN],
                                  rd: req_rd[win*REG_IDX +: REG_IDX], wen: req_rdwen[win]});
                    pref = 1 - win;
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_req();
        test_alternate();
        test_full();
        test_backpressure();
        test_flush();
        test_orphan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
